// File: rtl/pwm_multi.sv
// -----------------------------------------------------------------------------
// pwm_multi
// Multi-channel PWM generator sharing one period counter.
// Each channel has a host-written shadow duty register and an active duty
// register. Active duties are refreshed from the shadows only at period
// boundaries, so a host write never produces a glitched period.
//
// Ports
//   sysclk    : sole clock, rising edge
//   i_rst     : synchronous active-high reset
//   i_enb     : global enable (0 = counter parked at MAX, outputs low)
//   i_center  : 0 = edge-aligned, 1 = center-aligned (applied at period end)
//   i_wr      : duty write strobe
//   i_wr_ch   : channel index for write (out-of-range index is ignored)
//   i_wr_d    : duty value for write
//   o_pwm     : per-channel PWM outputs (registered)
//   o_cnt     : shared period counter (registered)
//   o_period  : one-cycle pulse on the last cycle of each period (registered)
// -----------------------------------------------------------------------------
module pwm_multi #(
    parameter int CH    = 4,
    parameter int WIDTH = 7,
    localparam int WCH  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             sysclk,
    input  logic             i_rst,
    input  logic             i_enb,
    input  logic             i_center,
    input  logic             i_wr,
    input  logic [WCH-1:0]   i_wr_ch,
    input  logic [WIDTH-1:0] i_wr_d,
    output logic [CH-1:0]    o_pwm,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_period
);

    localparam logic [WIDTH-1:0] MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    logic [WIDTH-1:0] shadow_r [CH];
    logic [WIDTH-1:0] active_r [CH];
    logic [WIDTH-1:0] cnt_r;
    logic             dir_down_r;   // center mode: 1 while counting down
    logic             mode_r;       // latched mode, 1 = center
    logic             parked_r;     // counter parked; next enabled edge restarts at 0
    logic [CH-1:0]    pwm_r;
    logic             period_r;

    logic [WIDTH-1:0] shadow_fwd_s [CH];
    logic [WIDTH-1:0] active_nxt_s [CH];
    logic [WIDTH-1:0] cnt_nxt_s;
    logic             dir_nxt_s;
    logic             mode_nxt_s;
    logic             parked_nxt_s;
    logic             period_end_s;
    logic             load_s;
    logic [CH-1:0]    pwm_nxt_s;
    logic             period_nxt_s;

    // Shadow values including this cycle's write, so a write landing on the
    // period-end edge is committed straight into the active register.
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            if (i_wr && (i_wr_ch == WCH'(c))) begin
                shadow_fwd_s[c] = i_wr_d;
            end else begin
                shadow_fwd_s[c] = shadow_r[c];
            end
        end
    end

    // Current cycle is the last one of a running period.
    always_comb begin
        if (parked_r) begin
            period_end_s = 1'b0;
        end else if (mode_r) begin
            period_end_s = dir_down_r && (cnt_r == ONE);
        end else begin
            period_end_s = (cnt_r == MAX);
        end
    end

    // Counter, direction, mode and park sequencing.
    always_comb begin
        cnt_nxt_s    = cnt_r;
        dir_nxt_s    = dir_down_r;
        mode_nxt_s   = mode_r;
        parked_nxt_s = parked_r;
        load_s       = 1'b0;
        if (!i_enb) begin
            cnt_nxt_s    = MAX;
            dir_nxt_s    = 1'b0;
            mode_nxt_s   = i_center;
            parked_nxt_s = 1'b1;
            load_s       = 1'b1;
        end else if (parked_r || period_end_s) begin
            // Fresh period: restart at 0 counting up with newly sampled mode.
            cnt_nxt_s    = ZERO;
            dir_nxt_s    = 1'b0;
            mode_nxt_s   = i_center;
            parked_nxt_s = 1'b0;
            load_s       = 1'b1;
        end else if (mode_r) begin
            if (!dir_down_r && (cnt_r == MAX)) begin
                cnt_nxt_s = MAX - ONE;
                dir_nxt_s = 1'b1;
            end else if (dir_down_r) begin
                cnt_nxt_s = cnt_r - ONE;
            end else begin
                cnt_nxt_s = cnt_r + ONE;
            end
        end else begin
            cnt_nxt_s = cnt_r + ONE;
        end
    end

    // Active duty selection and registered output precomputation.
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            if (load_s) begin
                active_nxt_s[c] = shadow_fwd_s[c];
            end else begin
                active_nxt_s[c] = active_r[c];
            end
            pwm_nxt_s[c] = i_enb && (cnt_nxt_s < active_nxt_s[c]);
        end
        if (!i_enb) begin
            period_nxt_s = 1'b0;
        end else if (mode_nxt_s) begin
            period_nxt_s = dir_nxt_s && (cnt_nxt_s == ONE);
        end else begin
            period_nxt_s = (cnt_nxt_s == MAX);
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge sysclk) begin
        if (i_rst) begin
            for (int c = 0; c < CH; c++) begin
                shadow_r[c] <= ZERO;
                active_r[c] <= ZERO;
            end
            cnt_r      <= MAX;
            dir_down_r <= 1'b0;
            mode_r     <= 1'b0;
            parked_r   <= 1'b1;
            pwm_r      <= '0;
            period_r   <= 1'b0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                shadow_r[c] <= shadow_fwd_s[c];
                active_r[c] <= active_nxt_s[c];
            end
            cnt_r      <= cnt_nxt_s;
            dir_down_r <= dir_nxt_s;
            mode_r     <= mode_nxt_s;
            parked_r   <= parked_nxt_s;
            pwm_r      <= pwm_nxt_s;
            period_r   <= period_nxt_s;
        end
    end

    assign o_pwm    = pwm_r;
    assign o_cnt    = cnt_r;
    assign o_period = period_r;

endmodule
